// File: rtl/sram_arbiter_pkg.sv
// sram_arbiter_pkg
// Shared definitions for the IF/MEM SRAM arbiter: FSM state encoding,
// grant encoding, the default SRAM access time and the wait-counter width.
package sram_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  typedef enum logic {
    GNT_IF  = 1'b0,
    GNT_MEM = 1'b1
  } grant_e;

  // Default number of cycles the SRAM needs per access (legal 1..15).
  localparam int unsigned SRAM_WAIT_DEFAULT = 4;

  // Wide enough to hold SRAM_WAIT-1 for the whole legal range.
  localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/sram_wait_counter.sv
// sram_wait_counter
// Down-counter that times one SRAM access.
//   clk  : clock
//   rst  : asynchronous active-high reset (counter -> 0)
//   load : start an access; counter loads WAIT-1
//   dec  : count down by one (saturates at 0)
//   zero : counter is 0, i.e. the current cycle is the last access cycle
module sram_wait_counter
  import sram_arbiter_pkg::*;
#(
  parameter int unsigned WAIT = SRAM_WAIT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic dec,
  output logic zero
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Loading WAIT-1 makes the access span exactly WAIT cycles, with the
  // final one seen as cnt==0.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = CNT_W'(WAIT - 1);
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter
// Shares one single-port SRAM between the instruction-fetch stage and the
// MEM stage. Each access runs IDLE -> ACCESS (SRAM_WAIT cycles) -> DONE,
// and the granted port gets a one-cycle ready pulse in DONE.
// Ports:
//   clk, rst                     : clock, asynchronous active-high reset
//   if_req/if_addr               : fetch request and byte address
//   if_rdata/if_ready            : fetched word and completion pulse
//   mem_rd_en/mem_wr_en          : load / store request (both = store)
//   mem_addr/mem_wdata           : byte address and store data
//   mem_rdata/mem_ready          : load result and completion pulse
//   if_freeze/mem_freeze         : pipeline stall requests
//   sram_en/sram_we/sram_addr/
//   sram_wdata/sram_rdata        : SRAM interface (word addressed)
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int unsigned SRAM_WAIT = SRAM_WAIT_DEFAULT,
  parameter int unsigned ADDR_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic [31:0]       if_rdata,
  output logic              if_ready,
  input  logic              mem_rd_en,
  input  logic              mem_wr_en,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic [31:0]       mem_rdata,
  output logic              mem_ready,
  output logic              if_freeze,
  output logic              mem_freeze,
  output logic              sram_en,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_wdata,
  input  logic [31:0]       sram_rdata
);

  state_e      state_q, state_d;
  grant_e      grant_q, grant_d;
  grant_e      last_grant_q, last_grant_d;
  logic        write_q, write_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] mem_rdata_q, mem_rdata_d;

  logic        mem_req;
  logic        cnt_load;
  logic        cnt_dec;
  logic        cnt_zero;
  logic        in_access;
  logic [31:0] granted_addr;

  assign mem_req = mem_rd_en | mem_wr_en;

  sram_wait_counter #(
    .WAIT(SRAM_WAIT)
  ) u_wait_cnt (
    .clk  (clk),
    .rst  (rst),
    .load (cnt_load),
    .dec  (cnt_dec),
    .zero (cnt_zero)
  );

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    write_d      = write_q;
    if_rdata_d   = if_rdata_q;
    mem_rdata_d  = mem_rdata_q;
    cnt_load     = 1'b0;
    cnt_dec      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (if_req || mem_req) begin
          state_d  = ST_ACCESS;
          cnt_load = 1'b1;
          // On a tie the port that was not served last wins.
          if (if_req && mem_req) begin
            grant_d = (last_grant_q == GNT_IF) ? GNT_MEM : GNT_IF;
          end else begin
            grant_d = mem_req ? GNT_MEM : GNT_IF;
          end
          last_grant_d = grant_d;
          // Read/write is frozen at grant so a withdrawn request cannot
          // turn a store into a read halfway through.
          write_d = (grant_d == GNT_MEM) && mem_wr_en;
        end
      end
      ST_ACCESS: begin
        cnt_dec = 1'b1;
        if (cnt_zero) begin
          state_d = ST_DONE;
          if (grant_q == GNT_IF) begin
            if_rdata_d = sram_rdata;
          end else if (!write_q) begin
            mem_rdata_d = sram_rdata;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      grant_q      <= GNT_IF;
      last_grant_q <= GNT_IF;
      write_q      <= 1'b0;
      if_rdata_q   <= '0;
      mem_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      write_q      <= write_d;
      if_rdata_q   <= if_rdata_d;
      mem_rdata_q  <= mem_rdata_d;
    end
  end

  // SRAM strobes are pure decodes of registered state, so an asynchronous
  // reset drops them in the same cycle.
  assign in_access    = (state_q == ST_ACCESS);
  assign granted_addr = (grant_q == GNT_MEM) ? mem_addr : if_addr;
  assign sram_en      = in_access;
  assign sram_we      = in_access && (grant_q == GNT_MEM) && write_q;
  assign sram_addr    = in_access ? granted_addr[ADDR_W+1:2] : '0;
  assign sram_wdata   = mem_wdata;

  assign if_ready  = (state_q == ST_DONE) && (grant_q == GNT_IF);
  assign mem_ready = (state_q == ST_DONE) && (grant_q == GNT_MEM);
  assign if_rdata  = if_rdata_q;
  assign mem_rdata = mem_rdata_q;

  assign if_freeze  = if_req & ~if_ready;
  assign mem_freeze = mem_req & ~mem_ready;

  // Byte-offset and high address bits are not part of the word address.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr[31:ADDR_W+2], if_addr[1:0],
                              mem_addr[31:ADDR_W+2], mem_addr[1:0]};

endmodule

// File: tb/tb_sram_arbiter.sv
module tb_sram_arbiter;

  localparam int W  = 4;
  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req;
  logic [31:0]   if_addr;
  logic [31:0]   if_rdata;
  logic          if_ready;
  logic          mem_rd_en;
  logic          mem_wr_en;
  logic [31:0]   mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;
  logic          mem_ready;
  logic          if_freeze;
  logic          mem_freeze;
  logic          sram_en;
  logic          sram_we;
  logic [AW-1:0] sram_addr;
  logic [31:0]   sram_wdata;
  logic [31:0]   sram_rdata;

  sram_arbiter #(.SRAM_WAIT(W), .ADDR_W(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_rdata   (if_rdata),
    .if_ready   (if_ready),
    .mem_rd_en  (mem_rd_en),
    .mem_wr_en  (mem_wr_en),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready),
    .if_freeze  (if_freeze),
    .mem_freeze (mem_freeze),
    .sram_en    (sram_en),
    .sram_we    (sram_we),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata)
  );

  always #5 clk = ~clk;

  // SRAM device: combinational read, write on the clock edge.
  logic [31:0] sram_arr [1024];
  assign sram_rdata = sram_arr[sram_addr[9:0]];
  always @(posedge clk) begin
    if (sram_en && sram_we) sram_arr[sram_addr[9:0]] <= sram_wdata;
  end

  // Reference model state.
  logic [31:0] model_mem [1024];
  bit          last_was_mem;
  logic [31:0] exp_if_rdata;
  logic [31:0] exp_mem_rdata;

  int vectors    = 0;
  int miscompares = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // One transaction (or a simultaneous IF+MEM pair) on a timeline derived
  // from the access rules: the request cycle is c=0, the first access
  // occupies c=1..W with ready at c=W+1; a losing requester is sampled in
  // the following IDLE cycle c=W+2 and completes at c=2W+3.
  // Entered and left just after a rising edge with the arbiter idle.
  task automatic run_pair(input bit do_if, input bit do_rd, input bit do_wr,
                          input logic [31:0] ia, input logic [31:0] ma,
                          input logic [31:0] wd, input int withdraw_c);
    bit mreq, first_mem, two;
    int if_start, mem_start, if_done, mem_done, end_c;
    bit in_if, in_mem;
    mreq = do_rd | do_wr;
    two  = do_if && mreq;
    first_mem = two ? !last_was_mem : mreq;
    if_start = -100; mem_start = -100; if_done = -1; mem_done = -1;
    if (mreq) begin
      mem_start = (first_mem) ? 0 : W + 2;
      mem_done  = mem_start + W + 1;
    end
    if (do_if) begin
      if_start = (first_mem && two) ? W + 2 : 0;
      if_done  = if_start + W + 1;
    end
    end_c = (two ? 2 * W + 3 : W + 1) + 2;

    if_req    = do_if;
    if_addr   = ia;
    mem_rd_en = do_rd;
    mem_wr_en = do_wr;
    mem_addr  = ma;
    mem_wdata = wd;

    for (int c = 0; c <= end_c; c++) begin
      @(negedge clk);
      in_if  = (c > if_start)  && (c <= if_start + W);
      in_mem = (c > mem_start) && (c <= mem_start + W);
      check_val("sram_en", sram_en, in_if | in_mem);
      check_val("sram_we", sram_we, in_mem & (do_wr == 1'b1));
      if (in_mem) check_val("sram_addr_mem", sram_addr, ma[AW+1:2]);
      if (in_if)  check_val("sram_addr_if",  sram_addr, ia[AW+1:2]);
      if (in_mem && do_wr) check_val("sram_wdata", sram_wdata, wd);
      check_val("if_ready",  if_ready,  c == if_done);
      check_val("mem_ready", mem_ready, c == mem_done);
      check_val("if_freeze",  if_freeze,  if_req & (c != if_done));
      check_val("mem_freeze", mem_freeze, (mem_rd_en | mem_wr_en) & (c != mem_done));
      if (c == if_done) exp_if_rdata = model_mem[ia[11:2]];
      if (c == mem_done) begin
        if (do_wr) begin
          model_mem[ma[11:2]] = wd;
          check_val("sram_written", sram_arr[ma[11:2]], wd);
        end else begin
          exp_mem_rdata = model_mem[ma[11:2]];
        end
      end
      check_val("if_rdata",  if_rdata,  exp_if_rdata);
      check_val("mem_rdata", mem_rdata, exp_mem_rdata);
      @(posedge clk);
      #1;
      if (c == if_done) if_req = 1'b0;
      if (c == mem_done || c + 1 == withdraw_c) begin
        mem_rd_en = 1'b0;
        mem_wr_en = 1'b0;
      end
    end
    last_was_mem = two ? !first_mem : first_mem;
  endtask

  // Store aborted by reset in its 3rd access cycle.
  task automatic reset_mid_write(input logic [31:0] ma, input logic [31:0] wd);
    mem_addr  = ma;
    mem_wdata = wd;
    mem_wr_en = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check_val("abort_pre_en", sram_en, 1'b1);
    rst = 1'b1;
    #1;
    check_val("abort_en", sram_en, 1'b0);
    check_val("abort_we", sram_we, 1'b0);
    check_val("abort_ready", mem_ready, 1'b0);
    check_val("abort_if_rdata", if_rdata, 32'h0);
    check_val("abort_mem_rdata", mem_rdata, 32'h0);
    // Two access edges already wrote the word before the abort.
    model_mem[ma[11:2]] = wd;
    check_val("abort_partial_wr", sram_arr[ma[11:2]], wd);
    exp_if_rdata  = 32'h0;
    exp_mem_rdata = 32'h0;
    last_was_mem  = 1'b0;
    @(negedge clk);
    mem_wr_en = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < W + 3; i++) begin
      @(negedge clk);
      check_val("post_abort_ready", {if_ready, mem_ready}, 2'b00);
      check_val("post_abort_en", sram_en, 1'b0);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] ia, ma, wd;
    bit          di;
    int          op;
    for (int i = 0; i < 1024; i++) begin
      sram_arr[i]  = $urandom;
      model_mem[i] = sram_arr[i];
    end
    last_was_mem  = 1'b0;
    exp_if_rdata  = 32'h0;
    exp_mem_rdata = 32'h0;
    rst = 1'b1;
    if_req = 1'b0; if_addr = '0;
    mem_rd_en = 1'b0; mem_wr_en = 1'b0; mem_addr = '0; mem_wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("rst_if_ready", if_ready, 1'b0);
    check_val("rst_mem_ready", mem_ready, 1'b0);
    check_val("rst_sram_en", sram_en, 1'b0);
    check_val("rst_sram_we", sram_we, 1'b0);
    check_val("rst_if_rdata", if_rdata, 32'h0);
    check_val("rst_mem_rdata", mem_rdata, 32'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Simultaneous pairs from reset: MEM first, then IF, twice.
    run_pair(1, 1, 0, 32'h0000_0020, 32'h0000_0044, 32'h0, -1);
    run_pair(1, 1, 0, 32'h0000_0108, 32'h0000_0204, 32'h0, -1);

    // Single fetch at 0x10.
    sram_arr[4]  = 32'hE3A0_1A01;
    model_mem[4] = 32'hE3A0_1A01;
    run_pair(1, 0, 0, 32'h0000_0010, 32'h0, 32'h0, -1);
    check_val("fetch_word", if_rdata, 32'hE3A0_1A01);

    // Store to 0x400, then read it back through the fetch port.
    run_pair(0, 0, 1, 32'h0, 32'h0000_0400, 32'h0000_1000, -1);
    run_pair(1, 0, 0, 32'h0000_0400, 32'h0, 32'h0, -1);
    check_val("store_readback", if_rdata, 32'h0000_1000);

    // Load withdrawn in its 2nd access cycle.
    run_pair(0, 1, 0, 32'h0, 32'h0000_0088, 32'h0, 2);

    // Both enables: treated as a store, load result untouched.
    run_pair(0, 1, 1, 32'h0, 32'h0000_0090, 32'hCAFE_F00D, -1);

    // Abort then check MEM wins first again.
    reset_mid_write(32'h0000_0600, 32'h1234_5678);
    run_pair(1, 1, 0, 32'h0000_0600, 32'h0000_0604, 32'h0, -1);

    // Random mix.
    for (int t = 0; t < 40; t++) begin
      di = 1'($urandom);
      op = int'($urandom_range(0, 3));
      if (op == 0 && !di) di = 1'b1;
      ia = {20'h0, 10'($urandom_range(0, 1023)), 2'($urandom)};
      ma = {20'h0, 10'($urandom_range(0, 1023)), 2'($urandom)};
      wd = $urandom;
      run_pair(di, op[0], op[1], ia, ma, wd, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
